// File: rtl/half_life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : half_life_pkg
// Description : Shared types and default parameters for the half-life decay
//               controller and its interval timer.
// Contents    : hl_state_t           controller state encoding
//               HL_DEFAULT_N         default counter width
//               HL_DEFAULT_HALF_LIFE default interval length in cycles
// Revision    : 1.0 - initial release
// ============================================================================
package half_life_pkg;

  localparam int HL_DEFAULT_N         = 4;
  localparam int HL_DEFAULT_HALF_LIFE = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DECAY = 3'd3,
    ST_DONE  = 3'd4
  } hl_state_t;

endpackage : half_life_pkg
`default_nettype wire

// File: rtl/hl_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : hl_interval_timer
// Description : Loadable down-counter that measures one half-life interval.
//               Counts down to zero and holds there until reloaded.
// Ports       : clk     in  system clock
//               rst     in  synchronous active-high reset (timer -> 0)
//               reload  in  set timer to HALF_LIFE-1 on the next edge
//               expired out high while the timer value is 0
// Revision    : 1.0 - initial release
// ============================================================================
module hl_interval_timer
  import half_life_pkg::*;
#(
  parameter int HALF_LIFE = HL_DEFAULT_HALF_LIFE
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic expired
);

  localparam int            TW         = $clog2(HALF_LIFE);
  localparam logic [TW-1:0] RELOAD_VAL = TW'(HALF_LIFE - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (reload) begin
      count <= RELOAD_VAL;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign expired = (count == '0);

endmodule : hl_interval_timer
`default_nettype wire

// File: rtl/half_life_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : half_life_ctrl
// Description : Command-side controller for an N-bit up/down/load counter.
//               Loads an initial value, then every HALF_LIFE cycles steps the
//               counter down until it holds half its previous value, until
//               the count reaches zero.
// Ports       : clk       in  system clock
//               rst       in  synchronous active-high reset
//               start     in  begin a decay run (sampled in IDLE only)
//               abort     in  cancel a run and clear the counter
//               init_val  in  value loaded into the counter at start
//               cnt       in  current (registered) counter value
//               cnt_clr   out counter clear command
//               cnt_down  out counter down command
//               cnt_load  out counter load command
//               cnt_up    out counter up command (always 0)
//               ld_val    out counter load value
//               busy      out high in LOAD, WAIT and DECAY
//               done      out one-cycle pulse at run completion
//               halvings  out completed halvings in current/last run
// Revision    : 1.0 - initial release
// ============================================================================
module half_life_ctrl
  import half_life_pkg::*;
#(
  parameter  int N         = HL_DEFAULT_N,
  parameter  int HALF_LIFE = HL_DEFAULT_HALF_LIFE,
  localparam int HW        = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  init_val,
  input  logic [N-1:0]  cnt,
  output logic          cnt_clr,
  output logic          cnt_down,
  output logic          cnt_load,
  output logic          cnt_up,
  output logic [N-1:0]  ld_val,
  output logic          busy,
  output logic          done,
  output logic [HW-1:0] halvings
);

  localparam logic [HW-1:0] HALV_MAX = HW'(N);

  hl_state_t    state;
  logic [N-1:0] target;
  logic         timer_reload;
  logic         timer_expired;
  logic         in_run;
  logic         halving_done;
  logic [N-1:0] cnt_pred;

  assign in_run = (state == ST_LOAD) || (state == ST_WAIT) || (state == ST_DECAY);

  // Halving completes on the first DECAY cycle where the live count is at
  // or below the target; using <= tolerates an externally lowered count.
  assign halving_done = (state == ST_DECAY) && (cnt <= target);

  // The timer starts a fresh interval on the edge that enters WAIT.
  assign timer_reload = !abort &&
                        ((state == ST_LOAD) || (halving_done && (target != '0)));

  // cnt_down is registered, so the count seen next cycle is the current one
  // minus the down currently being issued. Deciding the next pulse from this
  // prediction stops exactly at the target without overshoot.
  assign cnt_pred = cnt - N'(cnt_down);

  assign cnt_up = 1'b0;

  hl_interval_timer #(
    .HALF_LIFE (HALF_LIFE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .reload  (timer_reload),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      target   <= '0;
      cnt_clr  <= 1'b0;
      cnt_down <= 1'b0;
      cnt_load <= 1'b0;
      ld_val   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      halvings <= '0;
    end else begin
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
      done     <= 1'b0;

      if (in_run && abort) begin
        // Abort wins over start and over any pending halving update.
        state    <= ST_IDLE;
        cnt_clr  <= 1'b1;
        cnt_down <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt_down <= 1'b0;
            if (start) begin
              ld_val   <= init_val;
              halvings <= '0;
              cnt_load <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            state <= ST_WAIT;
          end

          ST_WAIT: begin
            if (timer_expired) begin
              if (cnt == '0) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end else begin
                // cnt is nonzero here, so it exceeds cnt>>1 and the first
                // down pulse is always required.
                target   <= cnt >> 1;
                cnt_down <= 1'b1;
                state    <= ST_DECAY;
              end
            end
          end

          ST_DECAY: begin
            if (halving_done) begin
              cnt_down <= 1'b0;
              if (halvings != HALV_MAX) begin
                halvings <= halvings + HW'(1);
              end
              if (target == '0) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end else begin
                state <= ST_WAIT;
              end
            end else begin
              cnt_down <= (cnt_pred > target);
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
          end

          default: begin
            cnt_down <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule : half_life_ctrl
`default_nettype wire

// File: doc/half_life_ctrl.md
# half_life_ctrl

Command-side controller for the team's N-bit up/down/load counter: drives the counter's `load`/`down`/clear inputs and reads back its count to emulate half-life decay. On `start` it loads an initial value. Every `HALF_LIFE` cycles it issues single-step `down` commands until the counter holds half its previous value (floor). It stops at zero. It sits beside the counter in the Half-Life Timer top and is the initiator of that counter's command interface.

## Interface
- `N`, 4, counter width; must match the attached counter.
- `HALF_LIFE`, 16, interval length in clock cycles; must be ≥ 2.
- `HW`, `$clog2(N+1)`, width of the halvings count (derived; not overridden).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a decay run; sampled only in IDLE.
- `abort`  in  1  cancel a run; clears the counter.
- `init_val`  in  N  value loaded into the counter at start.
- `cnt`  in  N  current counter output, registered inside the counter.
- `cnt_clr`  out  1  drives the counter's reset input.
- `cnt_down`  out  1  drives the counter's down input.
- `cnt_load`  out  1  drives the counter's load input.
- `cnt_up`  out  1  tied 0; present for interface completeness.
- `ld_val`  out  N  drives the counter's `in` input.
- `busy`  out  1  high in LOAD, WAIT and DECAY.
- `done`  out  1  one-cycle pulse at run completion.
- `halvings`  out  HW  number of completed halvings in the current or last run.

## Operation
- States: IDLE, LOAD, WAIT, DECAY, DONE.
- IDLE:
  - All command outputs are 0.
  - `start=1` captures `init_val` into `ld_val`, clears `halvings`, and moves to LOAD.
- LOAD:
  - `cnt_load=1` for exactly one cycle.
  - Moves to WAIT and sets the interval timer to `HALF_LIFE-1`.
- WAIT:
  - The timer decrements once per cycle.
  - When the timer reaches 0 and `cnt==0`, move to DONE.
  - When the timer reaches 0 and `cnt!=0`, latch `target = cnt>>1` and move to DECAY.
- DECAY:
  - While `cnt > target`, assert `cnt_down=1`, one pulse per cycle.
  - The first cycle where `cnt <= target` ends the halving: `cnt_down=0` and `halvings` increments.
  - After the halving, go to DONE if `target==0`; otherwise go to WAIT with the timer reloaded.
  - The `<=` compare means an externally lowered count never causes an underflow.
- DONE:
  - `done=1` for one cycle, then IDLE.
  - `halvings` holds its value until the next accepted start.
- `abort` while `busy`:
  - Next state is IDLE.
  - `cnt_clr=1` for one cycle (the cycle after `abort` is sampled).
  - No `done` pulse.
  - `halvings` holds its value.
- `abort` in IDLE or DONE: ignored.
- `start` while `busy`: ignored.
- `abort` and `start` both high while `busy`: abort wins.
- `halvings` saturates at `N`. This cannot be exceeded for legal counters.

## Timing
- Reset:
  - state is IDLE.
  - `cnt_clr`, `cnt_down`, `cnt_load`, `cnt_up`, `busy` and `done` are 0.
  - `ld_val` is 0 and `halvings` is 0.
  - Reset mid-run does not drive `cnt_clr`; the counter shares `rst`.
- All outputs are registered; there is no combinational path from input to output.
- Counter latency: a command asserted in cycle t is reflected on `cnt` in cycle t+1. DECAY compares the current `cnt`, so one `down` per cycle never overshoots.
- `start` sampled in cycle 0:
  - `cnt_load` and `busy` go high in cycle 1.
  - WAIT occupies cycles 2 .. 2+`HALF_LIFE`-1.
  - The first DECAY cycle is 2+`HALF_LIFE`.
- A halving from value v takes `v - floor(v/2)` down cycles plus 1 compare cycle.
- `done` rises one cycle after the final compare cycle.

## Structure
- Package `half_life_pkg`:
  - state enum `hl_state_t`.
  - `HL_DEFAULT_N` = 4.
  - `HL_DEFAULT_HALF_LIFE` = 16.
- Sub-module `hl_interval_timer`:
  - Loadable down-counter of width `$clog2(HALF_LIFE)`.
  - Ports: `clk`, `rst`, `reload`, `expired`.
  - `reload` sets the timer to `HALF_LIFE-1`; `expired` is high while the timer is at 0.
- Benches instantiate `half_life_ctrl` against the team's up/down/load counter with its `rst` driven by `rst | cnt_clr`.

## Test plan
- Decay from 12, `HALF_LIFE=4`, start in cycle 0:
  - cnt goes 12→6→3→1→0; downs per halving are 6, 3, 2, 1.
  - `halvings` reads 4 and `done` pulses once.
  - `cnt_load` is high in cycle 1 only.
- Decay from 15:
  - cnt goes 15→7→3→1→0; 15 downs in total.
  - `halvings=4`; `cnt_up` is never asserted.
- `init_val=0`:
  - Goes LOAD→WAIT→DONE after `HALF_LIFE` WAIT cycles.
  - `halvings=0`; no `cnt_down` is ever asserted.
- `abort` in the second DECAY of a run from 12:
  - `cnt_clr` pulses one cycle later and `cnt` reads 0.
  - State is IDLE, there is no `done`, and `halvings=1`.
- `start` pulsed while `busy`:
  - The run is unaffected and `ld_val` is unchanged.
  - A `start` taken in IDLE right after `done` starts a fresh run with `halvings` cleared.
- `rst` asserted mid-WAIT:
  - Next cycle, all outputs are at their reset values and state is IDLE.
  - The following `start` behaves as in the first scenario.
